// File: rtl/archinfo_apb4_if.sv
// ----------------------------------------------------------------------------
// apb4_if : APB4 bus bundle with master and slave views.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface apb4_if;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, pslverr, prdata
  );
endinterface

`default_nettype wire

// File: rtl/archinfo_apb4.sv
// ----------------------------------------------------------------------------
// archinfo_apb4 : APB4 architecture-ID block (writable SYS, read-only IDL/IDH).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module archinfo_apb4 #(
  parameter logic [31:0] SYS_RST = 32'h101F_1010,
  parameter logic [31:0] IDL_VAL = 32'hFFFF_2022,
  parameter logic [31:0] IDH_VAL = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  apb4_if.slave       apb,
  output logic [31:0] sys_o
);

  localparam logic [1:0] OFF_SYS = 2'd0;
  localparam logic [1:0] OFF_IDL = 2'd1;
  localparam logic [1:0] OFF_IDH = 2'd2;

  logic [31:0] sys_q;
  logic [31:0] sys_d;
  logic [1:0]  off;
  logic        wr_en;

  // Only word offset bits take part in decode; the rest are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{apb.paddr[31:4], apb.paddr[1:0], apb.pprot, apb.penable & 1'b0};

  assign off   = apb.paddr[3:2];
  assign wr_en = apb.psel & apb.penable & apb.pwrite & (off == OFF_SYS);

  always_comb begin
    sys_d = sys_q;
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (apb.pstrb[n]) begin
          sys_d[8*n +: 8] = apb.pwdata[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sys_q <= SYS_RST;
    end else begin
      sys_q <= sys_d;
    end
  end

  always_comb begin
    apb.prdata = 32'h0;
    if (apb.psel && !apb.pwrite) begin
      case (off)
        OFF_SYS: apb.prdata = sys_q;
        OFF_IDL: apb.prdata = IDL_VAL;
        OFF_IDH: apb.prdata = IDH_VAL;
        default: apb.prdata = 32'h0;
      endcase
    end
  end

  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;
  assign sys_o       = sys_q;

endmodule

`default_nettype wire

// File: tb/tb_archinfo_apb4.sv
// ----------------------------------------------------------------------------
// tb_archinfo_apb4 : directed + randomized bench with a register-map model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_archinfo_apb4;

  localparam logic [31:0] SYS_RST = 32'h101F_1010;
  localparam logic [31:0] IDL_VAL = 32'hFFFF_2022;
  localparam logic [31:0] IDH_VAL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sys_o;
  int          n_cmp = 0;
  int          n_fail = 0;

  apb4_if bus ();

  archinfo_apb4 #(
    .SYS_RST(SYS_RST),
    .IDL_VAL(IDL_VAL),
    .IDH_VAL(IDH_VAL)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .apb    (bus),
    .sys_o  (sys_o)
  );

  always #5 clk = ~clk;

  // Reference model: SYS word plus byte-mask merge on qualified writes.
  logic [31:0] sys_m = SYS_RST;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_m = SYS_RST;
    end else if (bus.psel && bus.penable && bus.pwrite && bus.paddr[3:2] == 2'd0) begin
      sys_m = (sys_m & ~strb_mask(bus.pstrb)) | (bus.pwdata & strb_mask(bus.pstrb));
    end
  end

  function automatic logic [31:0] exp_rd();
    if (!bus.psel || bus.pwrite) return 32'h0;
    case (bus.paddr[3:2])
      2'd0:    return sys_m;
      2'd1:    return IDL_VAL;
      2'd2:    return IDH_VAL;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_prdata", bus.prdata, exp_rd());
    check("cyc_sys_o", sys_o, sys_m);
    check("cyc_pready", {31'h0, bus.pready}, 32'h1);
    check("cyc_pslverr", {31'h0, bus.pslverr}, 32'h0);
  end

  task automatic bus_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'($urandom);
    bus.paddr   = $urandom;
    bus.pwdata  = $urandom;
    bus.pstrb   = 4'($urandom);
    bus.pprot   = 3'($urandom);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = d; bus.pstrb = s; bus.pprot = 3'($urandom);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    rd = bus.prdata;
    @(posedge clk); #1;
    bus_idle();
  endtask

  logic [31:0] rd;

  initial begin
    bus_idle();
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed register-map checks
    xfer(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, rd);
    check("rd_sys_reset", rd, 32'h101F_1010);
    xfer(1'b0, 32'hFFFF_0004, 32'h0, 4'h0, rd);
    check("rd_idl", rd, 32'hFFFF_2022);
    xfer(1'b0, 32'hFFFF_0008, 32'h0, 4'h0, rd);
    check("rd_idh", rd, 32'hFFFF_FFFF);

    xfer(1'b1, 32'hFFFF_0000, 32'hA5A5_5A5A, 4'b0101, rd);
    xfer(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, rd);
    check("rd_sys_strb", rd, 32'h10A5_105A);
    check("sys_o_strb", sys_o, 32'h10A5_105A);

    xfer(1'b1, 32'hFFFF_0004, 32'h1234_5678, 4'hF, rd);
    xfer(1'b1, 32'hFFFF_0008, 32'h1234_5678, 4'hF, rd);
    xfer(1'b1, 32'hFFFF_000C, 32'h1234_5678, 4'hF, rd);
    xfer(1'b0, 32'hFFFF_0004, 32'h0, 4'h0, rd);
    check("rd_idl_after_wr", rd, 32'hFFFF_2022);
    xfer(1'b0, 32'hFFFF_0008, 32'h0, 4'h0, rd);
    check("rd_idh_after_wr", rd, 32'hFFFF_FFFF);
    xfer(1'b0, 32'hFFFF_000C, 32'h0, 4'h0, rd);
    check("rd_rsvd", rd, 32'h0);
    check("sys_o_ro_wr", sys_o, 32'h10A5_105A);

    xfer(1'b1, 32'hFFFF_0000, 32'hFFFF_FFFF, 4'h0, rd);
    check("sys_o_strb0", sys_o, 32'h10A5_105A);

    // Async reset in the access phase of a SYS write
    xfer(1'b1, 32'hFFFF_0000, 32'hDEAD_BEEF, 4'hF, rd);
    check("sys_o_deadbeef", sys_o, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'hFFFF_0000; bus.pwdata = 32'h5555_5555; bus.pstrb = 4'hF;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("sys_o_async_rst", sys_o, 32'h101F_1010);
    repeat (3) @(posedge clk);
    #1 bus_idle();
    @(posedge clk); #1 rst_n = 1'b1;
    xfer(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, rd);
    check("rd_sys_after_rst", rd, 32'h101F_1010);

    xfer(1'b0, 32'h0000_0004, 32'h0, 4'h0, rd);
    check("rd_idl_base0", rd, 32'hFFFF_2022);
    @(negedge clk);
    check("idle_prdata", bus.prdata, 32'h0);

    // Randomized traffic; the per-cycle compare process checks everything.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[3:2] = 2'd0;
      case ($urandom_range(0, 3))
        0: begin
          @(posedge clk); #1 bus_idle();
        end
        1: xfer(1'b0, a, $urandom, 4'($urandom), rd);
        default: xfer(1'b1, a, $urandom, 4'($urandom), rd);
      endcase
    end

    @(posedge clk); #1 bus_idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
